binary_frame_thresholder: RTL and testbench

//  Upstream stage of the binary ROI capture buffer. Converts the camera's grayscale pixel stream to a
//  1-bit foreground stream, detects frame boundaries from blanking, and generates raster coordinates.

---
 rtl/binary_frame_thresholder_pkg.sv | 23 ++
 rtl/binary_frame_thresholder_blank_detector.sv | 46 ++++
 rtl/binary_frame_thresholder.sv | 186 ++++++++++++++++++
 tb/tb_binary_frame_thresholder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_frame_thresholder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | binary_frame_thresholder_pkg: shared geometry, widths and states |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package binary_frame_thresholder_pkg;

  localparam int c_IMG_W     = 320;
  localparam int c_IMG_H     = 240;
  localparam int c_PIX_W     = 8;
  localparam int c_BLANK_MIN = 400;
  localparam int c_X_W       = 9;
  localparam int c_Y_W       = 8;
  localparam int c_CNT_W     = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/binary_frame_thresholder_blank_detector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | blank_detector: saturating invalid-cycle counter with armed flag |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module blank_detector
  import binary_frame_thresholder_pkg::*;
#(
  parameter int BLANK_MIN = c_BLANK_MIN
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iDVAL,
  input  logic iClear,
  output logic oArmed,
  output logic oArmSet
);

  localparam int c_BLANK_CW = $clog2(BLANK_MIN + 1);

  logic [c_BLANK_CW-1:0] r_cnt;
  logic                  r_armed;

  // Arming happens on the edge where the counter lands on BLANK_MIN
  assign oArmSet = !iDVAL && (r_cnt == c_BLANK_CW'(BLANK_MIN - 1));
  assign oArmed  = r_armed;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      if (iDVAL)
        r_cnt <= '0;
      else if (r_cnt != c_BLANK_CW'(BLANK_MIN))
        r_cnt <= r_cnt + c_BLANK_CW'(1);

      if (oArmSet)
        r_armed <= 1'b1;
      else if (iClear)
        r_armed <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/binary_frame_thresholder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | binary_frame_thresholder: grayscale -> 1-bit stream, raster, bbox |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module binary_frame_thresholder
  import binary_frame_thresholder_pkg::*;
#(
  parameter int IMG_W     = c_IMG_W,
  parameter int IMG_H     = c_IMG_H,
  parameter int PIX_W     = c_PIX_W,
  parameter int BLANK_MIN = c_BLANK_MIN
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [PIX_W-1:0]   iDATA,
  input  logic               iDVAL,
  input  logic [PIX_W-1:0]   iThreshold,
  input  logic               iInvert,
  output logic               oDATA,
  output logic               oDVAL,
  output logic               oFrameStart,
  output logic [c_X_W-1:0]   oX,
  output logic [c_Y_W-1:0]   oY,
  output logic               oFrameDone,
  output logic               oFrameAbort,
  output logic               oBBoxValid,
  output logic [c_X_W-1:0]   oXMin,
  output logic [c_X_W-1:0]   oXMax,
  output logic [c_Y_W-1:0]   oYMin,
  output logic [c_Y_W-1:0]   oYMax,
  output logic [c_CNT_W-1:0] oFgCount
);

  state_t               r_state, w_stateNext;
  logic                 w_armed, w_armSet;
  logic                 w_start, w_accept, w_lastPix, w_fg;
  logic [PIX_W-1:0]     r_thr, w_thr;
  logic                 r_inv, w_inv;
  logic [c_X_W-1:0]     r_x, w_px;
  logic [c_Y_W-1:0]     r_y, w_py;
  logic [c_X_W-1:0]     r_xMin, r_xMax;
  logic [c_Y_W-1:0]     r_yMin, r_yMax;
  logic [c_CNT_W-1:0]   r_cnt, w_cntBase;
  logic                 r_lastDly;

  blank_detector #(.BLANK_MIN(BLANK_MIN)) u_blank (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDVAL   (iDVAL),
    .iClear  (w_start),
    .oArmed  (w_armed),
    .oArmSet (w_armSet)
  );

  // The start pixel is classified with the live threshold, later ones with the latched copy
  assign w_start   = iDVAL && w_armed && (r_state != ST_ACTIVE);
  assign w_accept  = iDVAL && ((r_state == ST_ACTIVE) || w_start);
  assign w_px      = w_start ? '0 : r_x;
  assign w_py      = w_start ? '0 : r_y;
  assign w_thr     = w_start ? iThreshold : r_thr;
  assign w_inv     = w_start ? iInvert : r_inv;
  assign w_fg      = (iDATA >= w_thr) ^ w_inv;
  assign w_cntBase = w_start ? '0 : r_cnt;
  assign w_lastPix = w_accept && (w_px == c_X_W'(IMG_W - 1)) && (w_py == c_Y_W'(IMG_H - 1));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE, ST_DRAIN: begin
        if (w_start) w_stateNext = w_lastPix ? ST_DRAIN : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_armSet)       w_stateNext = ST_IDLE;
        else if (w_lastPix) w_stateNext = ST_DRAIN;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x   <= '0;
      r_y   <= '0;
      r_thr <= '0;
      r_inv <= 1'b0;
    end else begin
      if (w_start) begin
        r_thr <= iThreshold;
        r_inv <= iInvert;
      end
      if (w_accept) begin
        if (w_px == c_X_W'(IMG_W - 1)) begin
          r_x <= '0;
          r_y <= w_py + c_Y_W'(1);
        end else begin
          r_x <= w_px + c_X_W'(1);
          r_y <= w_py;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL       <= 1'b0;
      oDATA       <= 1'b0;
      oFrameStart <= 1'b0;
      oX          <= '0;
      oY          <= '0;
    end else begin
      oDVAL       <= w_accept;
      oDATA       <= w_accept && w_fg;
      oFrameStart <= w_start;
      if (w_accept) begin
        oX <= w_px;
        oY <= w_py;
      end
    end
  end

  // Working bbox: an empty count means the next foreground pixel seeds min and max
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_cnt  <= '0;
      r_xMin <= '0;
      r_xMax <= '0;
      r_yMin <= '0;
      r_yMax <= '0;
    end else if (w_accept) begin
      if (w_fg) begin
        r_cnt <= w_cntBase + c_CNT_W'(1);
        if (w_cntBase == '0) begin
          r_xMin <= w_px;
          r_xMax <= w_px;
          r_yMin <= w_py;
          r_yMax <= w_py;
        end else begin
          if (w_px < r_xMin) r_xMin <= w_px;
          if (w_px > r_xMax) r_xMax <= w_px;
          if (w_py < r_yMin) r_yMin <= w_py;
          if (w_py > r_yMax) r_yMax <= w_py;
        end
      end else if (w_start) begin
        r_cnt  <= '0;
        r_xMin <= '0;
        r_xMax <= '0;
        r_yMin <= '0;
        r_yMax <= '0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_lastDly   <= 1'b0;
      oFrameDone  <= 1'b0;
      oFrameAbort <= 1'b0;
      oBBoxValid  <= 1'b0;
      oFgCount    <= '0;
      oXMin       <= '0;
      oXMax       <= '0;
      oYMin       <= '0;
      oYMax       <= '0;
    end else begin
      r_lastDly   <= w_lastPix;
      oFrameDone  <= r_lastDly;
      oFrameAbort <= (r_state == ST_ACTIVE) && w_armSet;
      if (r_lastDly) begin
        oBBoxValid <= (r_cnt != '0);
        oFgCount   <= r_cnt;
        oXMin      <= (r_cnt != '0) ? r_xMin : '0;
        oXMax      <= (r_cnt != '0) ? r_xMax : '0;
        oYMin      <= (r_cnt != '0) ? r_yMin : '0;
        oYMax      <= (r_cnt != '0) ? r_yMax : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_binary_frame_thresholder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_binary_frame_thresholder: random stimulus vs frame-level model |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_binary_frame_thresholder;
  import binary_frame_thresholder_pkg::*;

  localparam int W    = 12;
  localparam int H    = 6;
  localparam int BL   = 20;
  localparam int NPIX = W * H;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [7:0]  iDATA = '0;
  logic        iDVAL = 1'b0;
  logic [7:0]  iThreshold = 8'd128;
  logic        iInvert = 1'b0;
  logic        oDATA, oDVAL, oFrameStart, oFrameDone, oFrameAbort, oBBoxValid;
  logic [8:0]  oX, oXMin, oXMax;
  logic [7:0]  oY, oYMin, oYMax;
  logic [16:0] oFgCount;

  always #5 iCLK = ~iCLK;

  binary_frame_thresholder #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .BLANK_MIN(BL)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
    .iThreshold(iThreshold), .iInvert(iInvert),
    .oDATA(oDATA), .oDVAL(oDVAL), .oFrameStart(oFrameStart), .oX(oX), .oY(oY),
    .oFrameDone(oFrameDone), .oFrameAbort(oFrameAbort), .oBBoxValid(oBBoxValid),
    .oXMin(oXMin), .oXMax(oXMax), .oYMin(oYMin), .oYMax(oYMax), .oFgCount(oFgCount)
  );

  int nChecks = 0, nErr = 0;
  int dvalCount = 0, doneCount = 0, abortCount = 0, startCount = 0;

  // Frame-level model: pixel index within the frame, blank run length, stored fg map
  int  mBlank, mK, mThr;
  bit  mArmed, mCap, mPend, mInv;
  bit  mFg [NPIX];
  bit  eDval, eData, eStart, eDone, eAbort, eBVal;
  int  eX, eY, eXMin, eXMax, eYMin, eYMax, eCnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBlank = 0; mK = 0; mThr = 0; mArmed = 0; mCap = 0; mPend = 0; mInv = 0;
    eDval = 0; eData = 0; eStart = 0; eDone = 0; eAbort = 0; eBVal = 0;
    eX = 0; eY = 0; eXMin = 0; eXMax = 0; eYMin = 0; eYMax = 0; eCnt = 0;
  endtask

  task automatic modelStep();
    bit st, fg;
    int c, x0, x1, y0, y1, px, py;
    eDval = 0; eData = 0; eStart = 0; eDone = 0; eAbort = 0;
    if (mPend) begin
      c = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0;
      for (int k = 0; k < NPIX; k++) begin
        if (mFg[k]) begin
          px = k % W; py = k / W;
          if (c == 0) begin x0 = px; x1 = px; y0 = py; y1 = py; end
          else begin
            if (px < x0) x0 = px;
            if (px > x1) x1 = px;
            if (py < y0) y0 = py;
            if (py > y1) y1 = py;
          end
          c++;
        end
      end
      eCnt = c; eBVal = (c != 0); eXMin = x0; eXMax = x1; eYMin = y0; eYMax = y1;
      eDone = 1; mPend = 0;
    end
    if (iDVAL) begin
      mBlank = 0;
      st = mArmed && !mCap;
      if (st) begin
        mCap = 1; mK = 0; mThr = int'(iThreshold); mInv = iInvert; mArmed = 0;
        foreach (mFg[i]) mFg[i] = 0;
      end
      if (mCap) begin
        fg = (int'(iDATA) >= mThr) ^ mInv;
        eDval = 1; eData = fg; eStart = st; eX = mK % W; eY = mK / W;
        mFg[mK] = fg; mK++;
        if (mK == NPIX) begin mCap = 0; mPend = 1; end
      end
    end else if (mBlank < BL) begin
      mBlank++;
      if (mBlank == BL) begin
        mArmed = 1;
        if (mCap) begin mCap = 0; eAbort = 1; end
      end
    end
  endtask

  always @(posedge iCLK) if (iRST) modelStep();

  always @(negedge iCLK) begin
    check("oDVAL", oDVAL, eDval);
    check("oDATA", oDATA, eData);
    check("oFrameStart", oFrameStart, eStart);
    check("oFrameDone", oFrameDone, eDone);
    check("oFrameAbort", oFrameAbort, eAbort);
    if (eDval) begin
      check("oX", oX, eX);
      check("oY", oY, eY);
    end
    check("oBBoxValid", oBBoxValid, eBVal);
    check("oFgCount", oFgCount, eCnt);
    check("oXMin", oXMin, eXMin);
    check("oXMax", oXMax, eXMax);
    check("oYMin", oYMin, eYMin);
    check("oYMax", oYMax, eYMax);
    if (oDVAL) dvalCount++;
    if (oFrameDone) doneCount++;
    if (oFrameAbort) abortCount++;
    if (oFrameStart) startCount++;
  end

  task automatic cyc(input bit v, input logic [7:0] d);
    iDVAL = v; iDATA = d;
    @(posedge iCLK); #2;
  endtask

  task automatic blank(input int n);
    repeat (n) cyc(1'b0, 8'd0);
  endtask

  task automatic doReset();
    iRST = 1'b0; iDVAL = 1'b0; modelReset();
    @(posedge iCLK); #2;
    iRST = 1'b1;
  endtask

  function automatic logic [7:0] pix(input int mode, input int x, input int y);
    logic [7:0] v;
    case (mode)
      0:       v = 8'd200;
      1:       v = ((x == 3 && y == 1) || (x == 10 && y == 4)) ? 8'd255 : 8'd0;
      default: v = 8'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  task automatic frame(input int mode, input int nPix, input int gapPct, input int toggleAt);
    for (int k = 0; k < nPix; k++) begin
      if (gapPct > 0 && $urandom_range(0, 99) < gapPct) blank($urandom_range(1, 3));
      if (k == toggleAt) begin iInvert = ~iInvert; iThreshold = 8'($urandom_range(0, 255)); end
      cyc(1'b1, pix(mode, k % W, k / W));
    end
  endtask

  int d0, s0, a0, f0;

  initial begin
    modelReset();
    repeat (2) @(posedge iCLK);
    #2 iRST = 1'b1;

    // Solid frame above threshold
    blank(BL);
    frame(0, NPIX, 0, -1);
    blank(3);
    check("t1 count", oFgCount, 72);
    check("t1 bbox", {oXMin, oXMax, oYMin, oYMax}, {9'd0, 9'd11, 8'd0, 8'd5});
    check("t1 done", doneCount, 1);
    check("t1 dvals", dvalCount, 72);

    // Two isolated bright pixels
    blank(BL);
    frame(1, NPIX, 10, -1);
    blank(3);
    check("t2 count", oFgCount, 2);
    check("t2 bbox", {oXMin, oXMax, oYMin, oYMax}, {9'd3, 9'd10, 8'd1, 8'd4});
    check("t2 valid", oBBoxValid, 1);

    // Inverted, toggled mid-frame
    iInvert = 1'b1;
    blank(BL);
    frame(1, NPIX, 0, 30);
    iThreshold = 8'd128; iInvert = 1'b0;
    blank(3);
    check("t3 count", oFgCount, 70);

    // Short blank after reset does not arm
    doReset();
    d0 = dvalCount; s0 = startCount;
    blank(8);
    frame(0, 10, 0, -1);
    check("t4 no capture", dvalCount - d0, 0);
    blank(BL);
    frame(0, NPIX, 0, -1);
    blank(3);
    check("t4 one start", startCount - s0, 1);
    check("t4 count", oFgCount, 72);

    // Truncated frame aborts; results hold
    a0 = abortCount; f0 = doneCount;
    blank(BL);
    frame(2, 3 * W, 0, -1);
    blank(BL + 2);
    check("t5 abort", abortCount - a0, 1);
    check("t5 held count", oFgCount, 72);
    frame(0, NPIX, 0, -1);
    blank(3);
    check("t5 next done", doneCount - f0, 1);

    // Reset at (5,3), then drain pixels after a full frame
    blank(BL);
    frame(2, 3 * W + 5, 0, -1);
    doReset();
    check("t6 count cleared", oFgCount, 0);
    check("t6 dval cleared", oDVAL, 0);
    d0 = dvalCount;
    frame(0, 5, 0, -1);
    blank(BL);
    frame(2, NPIX, 0, -1);
    frame(0, 10, 0, -1);
    blank(3);
    check("t6 drain dropped", dvalCount - d0, NPIX);

    // Randomized frames with gaps, short blanks, partial frames and mid-frame changes
    for (int f = 0; f < 10; f++) begin
      iThreshold = 8'($urandom_range(0, 255));
      iInvert = 1'($urandom_range(0, 1));
      blank($urandom_range(BL - 3, BL + 5));
      frame(2, ($urandom_range(0, 2) == 0) ? $urandom_range(1, NPIX - 1) : NPIX,
            20, $urandom_range(0, NPIX));
    end
    blank(BL + 3);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
